// File: rtl/ysyx_22040759_mem_arbiter_pkg.sv
// rtl/ysyx_22040759_mem_arbiter_pkg.sv - shared types and codes for the IF/MEM bus arbiter
package ysyx_22040759_mem_arbiter_pkg;

  localparam int ARB_ADDR_W = 64;
  localparam int ARB_DATA_W = 64;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_IF_BUSY  = 2'd1,
    ARB_MEM_BUSY = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    ARB_OWN_NONE = 2'b00,
    ARB_OWN_IF   = 2'b01,
    ARB_OWN_MEM  = 2'b10
  } arb_owner_e;

  typedef enum logic [2:0] {
    SIZE_B = 3'b000,
    SIZE_H = 3'b001,
    SIZE_W = 3'b010,
    SIZE_D = 3'b011
  } arb_size_e;

endpackage

// File: rtl/ysyx_22040759_mem_arbiter_if.sv
// rtl/ysyx_22040759_mem_arbiter_if.sv - IF/MEM requester ports plus downstream request port
interface ysyx_22040759_mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_data_read;

  logic              mem_valid;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_write;
  logic [2:0]        mem_size;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_data_read;

  logic              out_valid;
  logic              out_req;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_wdata;
  logic [2:0]        out_size;
  logic              out_ready;
  logic [DATA_W-1:0] out_rdata;

  logic [1:0]        arb_owner;

  modport slave (
    input  if_valid, if_addr, mem_valid, mem_req, mem_addr, mem_data_write, mem_size,
    input  out_ready, out_rdata,
    output if_ready, if_data_read, mem_ready, mem_data_read,
    output out_valid, out_req, out_addr, out_wdata, out_size, arb_owner
  );

  modport master (
    output if_valid, if_addr, mem_valid, mem_req, mem_addr, mem_data_write, mem_size,
    output out_ready, out_rdata,
    input  if_ready, if_data_read, mem_ready, mem_data_read,
    input  out_valid, out_req, out_addr, out_wdata, out_size, arb_owner
  );
endinterface

// File: rtl/ysyx_22040759_mem_arbiter_arb_pick.sv
// rtl/ysyx_22040759_mem_arbiter_arb_pick.sv - grant selection; ARB_ROUND_ROBIN_EN swaps fixed MEM priority for alternation
module ysyx_22040759_arb_pick
  import ysyx_22040759_mem_arbiter_pkg::*;
(
  input  logic       i_if_valid,
  input  logic       i_mem_valid,
  input  arb_owner_e i_last_owner,
  output logic       o_grant_if,
  output logic       o_grant_mem
);

`ifdef ARB_ROUND_ROBIN_EN
  logic w_both;
  assign w_both      = i_if_valid & i_mem_valid;
  // On contention the requester that did not win last time goes first.
  assign o_grant_mem = i_mem_valid & ~(w_both & (i_last_owner == ARB_OWN_MEM));
  assign o_grant_if  = i_if_valid & ~o_grant_mem;
`else
  logic w_unused_last_owner;
  assign w_unused_last_owner = ^{i_last_owner};
  assign o_grant_mem = i_mem_valid;
  assign o_grant_if  = i_if_valid & ~i_mem_valid;
`endif

endmodule

// File: rtl/ysyx_22040759_mem_arbiter.sv
// rtl/ysyx_22040759_mem_arbiter.sv - shares one downstream request port between IF and MEM
// Optional ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests.
module ysyx_22040759_mem_arbiter
  import ysyx_22040759_mem_arbiter_pkg::*;
#(
  parameter int         ADDR_W  = ARB_ADDR_W,
  parameter int         DATA_W  = ARB_DATA_W,
  parameter logic [2:0] IF_SIZE = SIZE_D
) (
  input logic                        i_clock,
  input logic                        i_reset,
  ysyx_22040759_mem_arbiter_if.slave io_bus
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_out_req;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_wdata;
  logic [2:0]        r_out_size;
  logic              w_grant_if;
  logic              w_grant_mem;
  logic              w_if_ready;
  logic              w_mem_ready;
  arb_owner_e        w_owner;
  arb_owner_e        w_last_owner;

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_e r_last_owner;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_last_owner <= ARB_OWN_IF;
    end else if (r_state == ARB_IDLE && w_grant_mem) begin
      r_last_owner <= ARB_OWN_MEM;
    end else if (r_state == ARB_IDLE && w_grant_if) begin
      r_last_owner <= ARB_OWN_IF;
    end
  end
  assign w_last_owner = r_last_owner;
`else
  assign w_last_owner = ARB_OWN_IF;
`endif

  ysyx_22040759_arb_pick u_pick (
    .i_if_valid  (io_bus.if_valid),
    .i_mem_valid (io_bus.mem_valid),
    .i_last_owner(w_last_owner),
    .o_grant_if  (w_grant_if),
    .o_grant_mem (w_grant_mem)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_if_ready  = 1'b0;
    w_mem_ready = 1'b0;
    w_owner     = ARB_OWN_NONE;
    case (r_state)
      ARB_IDLE: begin
        if (w_grant_mem) begin
          w_state_nxt = ARB_MEM_BUSY;
        end else if (w_grant_if) begin
          w_state_nxt = ARB_IF_BUSY;
        end
      end
      ARB_IF_BUSY: begin
        w_owner    = ARB_OWN_IF;
        w_if_ready = io_bus.out_ready;
        if (io_bus.out_ready) w_state_nxt = ARB_IDLE;
      end
      ARB_MEM_BUSY: begin
        w_owner     = ARB_OWN_MEM;
        w_mem_ready = io_bus.out_ready;
        if (io_bus.out_ready) w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request fields are captured only in IDLE, so they stay frozen for the whole busy period.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_out_req   <= 1'b0;
      r_out_addr  <= '0;
      r_out_wdata <= '0;
      r_out_size  <= 3'b000;
    end else if (r_state == ARB_IDLE) begin
      if (w_grant_mem) begin
        r_out_req   <= io_bus.mem_req;
        r_out_addr  <= io_bus.mem_addr;
        r_out_wdata <= io_bus.mem_data_write;
        r_out_size  <= io_bus.mem_size;
      end else if (w_grant_if) begin
        r_out_req   <= 1'b0;
        r_out_addr  <= io_bus.if_addr;
        r_out_wdata <= '0;
        r_out_size  <= IF_SIZE;
      end
    end
  end

  assign io_bus.out_valid     = (r_state != ARB_IDLE);
  assign io_bus.out_req       = r_out_req;
  assign io_bus.out_addr      = r_out_addr;
  assign io_bus.out_wdata     = r_out_wdata;
  assign io_bus.out_size      = r_out_size;
  assign io_bus.arb_owner     = w_owner;
  assign io_bus.if_ready      = w_if_ready;
  assign io_bus.mem_ready     = w_mem_ready;
  assign io_bus.if_data_read  = w_if_ready ? io_bus.out_rdata : '0;
  assign io_bus.mem_data_read = w_mem_ready ? io_bus.out_rdata : '0;

endmodule

// File: tb/tb_ysyx_22040759_mem_arbiter.sv
// tb/tb_ysyx_22040759_mem_arbiter.sv - scoreboard bench for the IF/MEM arbiter
module tb_ysyx_22040759_mem_arbiter;
  import ysyx_22040759_mem_arbiter_pkg::*;

  typedef struct packed {
    logic [1:0]  own;
    logic        req;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  size;
  } grant_t;

  typedef struct packed {
    logic [1:0]  own;
    logic [63:0] data;
  } rdy_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_22040759_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  ysyx_22040759_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .IF_SIZE(3'b011)) dut (
    .i_clock(clk),
    .i_reset(rst),
    .io_bus (bus)
  );

  grant_t     exp_grant[$];
  rdy_t       exp_rdy[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] m_owner = ARB_OWN_NONE;
  logic [1:0] m_last = ARB_OWN_IF;
  bit         done_if, done_mem;
  bit         if_active, mem_active;
  int         busy_cnt, busy_delay;
  bit         mon_en = 1'b0;
  logic       prev_valid = 1'b0;
  grant_t     cur;
  rdy_t       r;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level reference: one owner at a time, chosen from the requests seen in an idle cycle.
  task automatic model_edge();
    bit     pick_mem;
    grant_t g;
    done_if  = 1'b0;
    done_mem = 1'b0;
    if (rst) begin
      m_owner = ARB_OWN_NONE;
      m_last  = ARB_OWN_IF;
    end else if (m_owner == ARB_OWN_NONE) begin
      pick_mem = bus.mem_valid;
`ifdef ARB_ROUND_ROBIN_EN
      if (bus.mem_valid && bus.if_valid) pick_mem = (m_last != ARB_OWN_MEM);
`endif
      if (pick_mem) begin
        g = '{own: ARB_OWN_MEM, req: bus.mem_req, addr: bus.mem_addr,
              wdata: bus.mem_data_write, size: bus.mem_size};
        exp_grant.push_back(g);
        m_owner = ARB_OWN_MEM;
      end else if (bus.if_valid) begin
        g = '{own: ARB_OWN_IF, req: 1'b0, addr: bus.if_addr, wdata: 64'd0, size: 3'b011};
        exp_grant.push_back(g);
        m_owner = ARB_OWN_IF;
      end
      if (m_owner != ARB_OWN_NONE) begin
        m_last     = m_owner;
        busy_cnt   = 0;
        busy_delay = $urandom_range(0, 3);
      end
    end else if (bus.out_ready) begin
      if (m_owner == ARB_OWN_IF) done_if = 1'b1;
      else done_mem = 1'b1;
      m_owner = ARB_OWN_NONE;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_ready(input bit rdy, input logic [63:0] d);
    rdy_t e;
    bus.out_ready = rdy;
    bus.out_rdata = d;
    if (rdy && m_owner != ARB_OWN_NONE) begin
      e = '{own: m_owner, data: d};
      exp_rdy.push_back(e);
    end
  endtask

  task automatic auto_step(input int p_new, input int p_stray, input int p_rst, input bit addr_wiggle);
    tick();
    rst = 1'b0;
    if (done_if) if_active = 1'b0;
    if (done_mem) mem_active = 1'b0;
    if (!if_active && $urandom_range(0, 99) < p_new) begin
      if_active   = 1'b1;
      bus.if_addr = 64'h8000_0000 + 64'({$urandom_range(0, 4095), 2'b00});
    end
    bus.if_valid = if_active;
    if (m_owner == ARB_OWN_IF && addr_wiggle && $urandom_range(0, 3) == 0)
      bus.if_addr = 64'h9000_0000 + 64'({$urandom_range(0, 4095), 2'b00});
    if (!mem_active && $urandom_range(0, 99) < p_new) begin
      mem_active         = 1'b1;
      bus.mem_req        = 1'($urandom_range(0, 1));
      bus.mem_addr       = 64'h8000_1000 + 64'({$urandom_range(0, 1023), 3'b000});
      bus.mem_data_write = {$urandom, $urandom};
      bus.mem_size       = 3'($urandom_range(0, 3));
    end
    bus.mem_valid = mem_active;
    if (m_owner != ARB_OWN_NONE) begin
      if (p_rst > 0 && $urandom_range(0, 99) < p_rst) begin
        rst = 1'b1;
        drive_ready(1'b0, {$urandom, $urandom});
      end else begin
        drive_ready(busy_cnt >= busy_delay, {$urandom, $urandom});
      end
      busy_cnt++;
    end else begin
      drive_ready($urandom_range(0, 99) < p_stray, {$urandom, $urandom});
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((if_active || mem_active || m_owner != ARB_OWN_NONE) && k < 300) begin
      auto_step(0, 0, 0, 1'b0);
      k++;
    end
    check("drain_idle", 192'({if_active, mem_active, m_owner}), 192'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("owner", 192'(bus.arb_owner), 192'(m_owner));
      check("out_valid", 192'(bus.out_valid), 192'(m_owner != ARB_OWN_NONE));
      if (bus.out_valid) begin
        if (!prev_valid) begin
          if (exp_grant.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL grant: got unexpected grant owner %b expected none", bus.arb_owner);
          end else begin
            cur = exp_grant.pop_front();
          end
        end
        check(prev_valid ? "hold_fields" : "grant_fields",
              192'({bus.arb_owner, bus.out_req, bus.out_addr, bus.out_wdata, bus.out_size}),
              192'(cur));
      end
      prev_valid = bus.out_valid;
      if (bus.if_ready || bus.mem_ready) begin
        if (exp_rdy.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stray_ready: got if_ready=%b mem_ready=%b expected none",
                   bus.if_ready, bus.mem_ready);
        end else begin
          r = exp_rdy.pop_front();
          check("ready_pulse",
                192'({bus.if_ready, bus.mem_ready, bus.if_data_read, bus.mem_data_read}),
                192'({r.own == ARB_OWN_IF, r.own == ARB_OWN_MEM,
                      (r.own == ARB_OWN_IF) ? r.data : 64'd0,
                      (r.own == ARB_OWN_MEM) ? r.data : 64'd0}));
        end
      end else begin
        if (exp_rdy.size() != 0) begin
          r = exp_rdy.pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL missed_ready: got no ready expected owner %b data %h", r.own, r.data);
        end
        check("idle_data", 192'({bus.if_data_read, bus.mem_data_read}), 192'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.if_valid = 0; bus.if_addr = '0;
    bus.mem_valid = 0; bus.mem_req = 0; bus.mem_addr = '0;
    bus.mem_data_write = '0; bus.mem_size = '0;
    bus.out_ready = 0; bus.out_rdata = '0;
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("reset_state",
          192'({bus.out_valid, bus.out_req, bus.out_addr, bus.out_wdata, bus.out_size,
                bus.arb_owner, bus.if_ready, bus.mem_ready}), 192'd0);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // IF-only fetch answered on the third busy cycle
    bus.if_addr = 64'h8000_0000; bus.if_valid = 1'b1;
    tick(); drive_ready(1'b0, 64'd0);
    tick(); drive_ready(1'b0, 64'd0);
    tick(); drive_ready(1'b1, 64'h0000_0013_0000_0093);
    tick(); drive_ready(1'b0, 64'd0); bus.if_valid = 1'b0;
    tick();

    // MEM write
    bus.mem_valid = 1'b1; bus.mem_req = 1'b1; bus.mem_addr = 64'h8000_1000;
    bus.mem_data_write = 64'hDEAD_BEEF; bus.mem_size = 3'b011;
    tick(); drive_ready(1'b0, 64'd0);
    tick(); drive_ready(1'b1, 64'd0);
    tick(); drive_ready(1'b0, 64'd0); bus.mem_valid = 1'b0;
    tick();

    // Simultaneous single requests, then continuously re-issued requests
    if_active = 1'b1; mem_active = 1'b1;
    bus.if_addr = 64'h8000_0100; bus.mem_req = 1'b0; bus.mem_addr = 64'h8000_2000;
    bus.if_valid = 1'b1; bus.mem_valid = 1'b1;
    drain();
    if_active = 1'b1; mem_active = 1'b1;
    bus.if_valid = 1'b1; bus.mem_valid = 1'b1;
    repeat (40) auto_step(100, 0, 0, 1'b0);
    drain();

    // Stray out_ready while idle, then address moved under a busy IF grant
    tick(); drive_ready(1'b1, 64'h5555_5555_5555_5555);
    tick(); drive_ready(1'b0, 64'd0);
    bus.if_addr = 64'h8000_0000; bus.if_valid = 1'b1;
    tick(); drive_ready(1'b0, 64'd0); bus.if_addr = 64'h8000_0004;
    tick(); drive_ready(1'b1, 64'h1234_5678_9abc_def0);
    tick(); drive_ready(1'b0, 64'd0); bus.if_valid = 1'b0;
    tick();

    // Reset during MEM_BUSY before out_ready
    bus.mem_valid = 1'b1; bus.mem_req = 1'b0; bus.mem_addr = 64'h8000_3000; bus.mem_size = 3'b010;
    tick(); drive_ready(1'b0, 64'd0);
    tick(); rst = 1'b1; bus.mem_valid = 1'b0;
    tick(); rst = 1'b0;
    @(negedge clk);
    check("post_reset", 192'({bus.out_valid, bus.arb_owner, bus.mem_ready}), 192'd0);
    #1;
    tick();

    // Randomized traffic with stray readies, address wiggle and occasional reset
    if_active = 1'b0; mem_active = 1'b0;
    repeat (1500) auto_step(30, 20, 2, 1'b1);
    drain();
    tick();
    tick();
    @(negedge clk);
    check("queues_empty", 192'({exp_grant.size(), exp_rdy.size()}), 192'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22040759_mem_arbiter.md
Name: ysyx_22040759_mem_arbiter

Overview:
- Shares one downstream bus-request port (toward the AXI master) between the fetch requester (IF) and the load/store requester (MEM).
- Each requester uses a valid/ready handshake. The arbiter grants one requester at a time, latches its request fields, and holds the grant until the downstream ready pulse.
- Sits between the CPU top's IF/MEM request ports and the AXI bridge.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, read/write data width.
- IF_SIZE, 3'b011, transfer size driven downstream for IF reads (IF is read-only).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- if_valid  in  1  fetch request pending; held high until if_ready
- if_addr  in  ADDR_W  fetch address; stable while if_valid
- if_ready  out  1  one-cycle completion pulse to IF
- if_data_read  out  DATA_W  fetch data; valid only when if_ready
- mem_valid  in  1  load/store request pending; held high until mem_ready
- mem_req  in  1  1 = write, 0 = read
- mem_addr  in  ADDR_W  data address
- mem_data_write  in  DATA_W  store data
- mem_size  in  3  transfer size code
- mem_ready  out  1  one-cycle completion pulse to MEM
- mem_data_read  out  DATA_W  load data; valid only when mem_ready
- out_valid  out  1  downstream request valid
- out_req  out  1  downstream write flag
- out_addr  out  ADDR_W  latched address
- out_wdata  out  DATA_W  latched write data
- out_size  out  3  latched size
- out_ready  in  1  downstream completion pulse; rdata valid in the same cycle
- out_rdata  in  DATA_W  downstream read data
- arb_owner  out  2  current owner: 00 none, 01 IF, 10 MEM

Behaviour:
- Clocking and reset: single clock; reset is synchronous, active-high, sampled on the rising edge of clock.
- Reset values: state IDLE; out_valid, out_req, out_addr, out_wdata, out_size all 0; arb_owner 00. if_ready, mem_ready, if_data_read and mem_data_read read 0 because they are gated by state.
- FSM states: IDLE, IF_BUSY, MEM_BUSY.
- IDLE:
  - If a requester valid is seen, register its fields into out_* and set out_valid=1 at the clock edge. The next state is that requester's BUSY state.
  - If neither is valid, stay in IDLE.
- Simultaneous IF and MEM valid in IDLE: MEM wins (fixed priority; see Optional Feature).
- Field latching on grant:
  - IF grant: out_req=0, out_addr=if_addr, out_wdata=0, out_size=IF_SIZE.
  - MEM grant: out_req=mem_req, out_addr=mem_addr, out_wdata=mem_data_write, out_size=mem_size.
- BUSY states:
  - out_* remain stable.
  - Ready to the owner is combinational: if_ready = (state==IF_BUSY) & out_ready; mem_ready = (state==MEM_BUSY) & out_ready.
  - Read data is gated pass-through: xx_data_read = xx_ready ? out_rdata : 0.
  - On out_ready, the next state is IDLE and out_valid clears at that edge.
- Latency:
  - The first out_valid appears 1 cycle after the requester's valid is sampled in IDLE.
  - There is a mandatory single IDLE cycle between back-to-back transactions. This lets the requester update its address after its ready pulse.
- out_ready in IDLE is ignored; no ready pulse reaches either requester.
- A non-owner's valid is ignored while the bus is BUSY. It is serviced on the next IDLE cycle.
- If a requester drops valid while BUSY (a protocol violation), the transaction still completes and the ready pulse is still issued.
- Reset mid-transaction: return to IDLE next edge, out_valid=0, in-flight result discarded. The downstream bridge shares the same reset.
- arb_owner = 01 in IF_BUSY, 10 in MEM_BUSY, 00 in IDLE.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A last_owner register is added, reset to IF.
  - On a simultaneous request in IDLE, the requester that is not last_owner wins.
  - last_owner updates on every grant.
  - Single requests are granted regardless of last_owner.
- Undefined: fixed MEM-over-IF priority and no last_owner register.

Decomposition:
- ysyx_22040759_define.v holds:
  - state encodings ARB_IDLE, ARB_IF_BUSY, ARB_MEM_BUSY;
  - owner codes ARB_OWN_NONE/IF/MEM;
  - size codes SIZE_B/H/W/D.
- One natural sub-module, ysyx_22040759_arb_pick:
  - inputs if_valid, mem_valid, last_owner;
  - output grant_if, grant_mem (one-hot or none);
  - its priority behaviour is selected by the macro.

Test Plan:
- IF only, if_valid=1, if_addr=0x80000000, out_ready pulsed on the 3rd busy cycle with out_rdata=0x00000013_00000093 -> out_valid rises 1 cycle after the request; out_size=3'b011, out_req=0; if_ready is a 1-cycle pulse with matching data; out_valid=0 next cycle.
- MEM write: mem_req=1, mem_addr=0x80001000, mem_data_write=0xDEADBEEF, mem_size=3'b011 -> out_* carry those values; mem_ready pulses on out_ready; mem_data_read=0.
- Simultaneous if_valid and mem_valid, macro undefined -> MEM granted first; IF granted after one IDLE cycle; arb_owner sequence 10,00,01.
- Simultaneous requests held continuously with ARB_ROUND_ROBIN_EN -> grants alternate MEM, IF, MEM, IF.
- Stray out_ready in IDLE, plus if_addr changed to 0x80000004 while IF_BUSY -> no ready pulse in IDLE; out_addr stays at the originally latched 0x80000000.
- Reset asserted in MEM_BUSY before out_ready -> next cycle out_valid=0, arb_owner=00, no mem_ready pulse.
